// File: rtl/median_line_ctrl.sv
// 3x1 column former for a median filter: two external BRAM line buffers.
// Define MEDIAN_LB_BORDER_EN to emit zero-padded columns for rows 0 and 1.
module median_line_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_WIDTH  = 12,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   pix_valid_i,
  input  logic [PIX_WIDTH-1:0]   pix_i,
  output logic                   pix_ready_o,
  output logic                   col_valid_o,
  output logic [3*PIX_WIDTH-1:0] col_o,
  input  logic                   col_ready_i,
  output logic [15:0]            col_x_o,
  output logic [15:0]            col_y_o,
  output logic                   done_o,
  output logic                   lb_wr_en_o,
  output logic                   lb_rd_en_o,
  output logic [ADDR_WIDTH-1:0]  lb_wr_addr_o,
  output logic [ADDR_WIDTH-1:0]  lb_rd_addr_o,
  output logic [PIX_WIDTH-1:0]   lb0_wdata_o,
  output logic [PIX_WIDTH-1:0]   lb1_wdata_o,
  input  logic [PIX_WIDTH-1:0]   lb0_rdata_i,
  input  logic [PIX_WIDTH-1:0]   lb1_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

`ifdef MEDIAN_LB_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  localparam logic [15:0] XMAX = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] YMAX = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] YEND = 16'(IMG_HEIGHT);

  state_e                 state_q, state_d;
  logic [15:0]            x_q, x_d;
  logic [15:0]            y_q, y_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [PIX_WIDTH-1:0]   wr_pix_q, wr_pix_d;
  logic                   col_valid_q, col_valid_d;
  logic [PIX_WIDTH-1:0]   col_pix_q, col_pix_d;
  logic [15:0]            col_x_q, col_x_d;
  logic [15:0]            col_y_q, col_y_d;

  logic busy, ready, accept, col_hs, last_hs, load;
  logic [PIX_WIDTH-1:0] top, mid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_pix_q    <= '0;
      col_valid_q <= 1'b0;
      col_pix_q   <= '0;
      col_x_q     <= '0;
      col_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_pix_q    <= wr_pix_d;
      col_valid_q <= col_valid_d;
      col_pix_q   <= col_pix_d;
      col_x_q     <= col_x_d;
      col_y_q     <= col_y_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    wr_pend_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_pix_d    = wr_pix_q;
    col_valid_d = col_valid_q;
    col_pix_d   = col_pix_q;
    col_x_d     = col_x_q;
    col_y_d     = col_y_q;

    busy    = (state_q != IDLE);
    // y reaches IMG_HEIGHT once the last pixel is in; stop taking more
    ready   = busy && (y_q != YEND) && (!col_valid_q || col_ready_i);
    accept  = pix_valid_i && ready;
    col_hs  = col_valid_q && col_ready_i;
    last_hs = col_hs && (col_x_q == XMAX) && (col_y_q == YMAX);
    load    = accept && (BORDER || (state_q == RUN));

    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = FILL;
        x_d     = '0;
        y_d     = '0;
      end
      FILL: if (accept && (x_q == XMAX) && (y_q == 16'd1))
        state_d = RUN;
      RUN: if (last_hs)
        state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      wr_pend_d = 1'b1;
      wr_addr_d = x_q[ADDR_WIDTH-1:0];
      wr_pix_d  = pix_i;
      if (x_q == XMAX) begin
        x_d = '0;
        y_d = y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end

    if (load) begin
      col_valid_d = 1'b1;
      col_pix_d   = pix_i;
      col_x_d     = x_q;
      col_y_d     = y_q;
    end else if (col_hs) begin
      col_valid_d = 1'b0;
    end

    // read data is held by the BRAM until the next accepted pixel
    top = lb1_rdata_i;
    mid = lb0_rdata_i;
    if (BORDER && (col_y_q < 16'd2)) top = '0;
    if (BORDER && (col_y_q == 16'd0)) mid = '0;
  end

  assign pix_ready_o  = ready;
  assign col_valid_o  = col_valid_q;
  assign col_o        = col_valid_q ? {top, mid, col_pix_q} : '0;
  assign col_x_o      = col_x_q;
  assign col_y_o      = col_y_q;
  assign done_o       = last_hs;
  assign lb_rd_en_o   = accept;
  assign lb_rd_addr_o = accept ? x_q[ADDR_WIDTH-1:0] : '0;
  assign lb_wr_en_o   = wr_pend_q;
  assign lb_wr_addr_o = wr_addr_q;
  assign lb0_wdata_o  = wr_pix_q;
  assign lb1_wdata_o  = wr_pend_q ? lb0_rdata_i : '0;

endmodule
